// File: rtl/gpi_debounce.sv
// gpi_debounce: per-bit two-flop synchroniser and debouncer for mechanical
// switch pads (navigation switch + user DIP switches).
//
// Ports:
//   clk_sys_i     system clock
//   rst_sys_ni    asynchronous active-low reset
//   gp_raw_i      raw asynchronous pad levels
//   gp_o          debounced, polarity-corrected levels (registered)
//   gp_rise_o     one-cycle strobe per bit on an accepted 0->1 of gp_o
//   gp_fall_o     one-cycle strobe per bit on an accepted 1->0 of gp_o
//   change_clr_i  write-1-to-clear for sticky change flags   (GPI_DEBOUNCE_IRQ_EN)
//   change_o      sticky per-bit change flags                (GPI_DEBOUNCE_IRQ_EN)
//   irq_o         OR of change_o, registered                 (GPI_DEBOUNCE_IRQ_EN)
//
// Optional feature macro: GPI_DEBOUNCE_IRQ_EN adds the sticky change flags and
// interrupt output. Without it those ports and flops do not exist.
module gpi_debounce #(
    parameter int unsigned      Width          = 13,
    parameter int unsigned      DebounceCycles = 150000,
    parameter logic [Width-1:0] InvertMask     = {Width{1'b1}},
    parameter logic [Width-1:0] ResetValue     = {Width{1'b0}}
) (
    input  logic             clk_sys_i,
    input  logic             rst_sys_ni,
    input  logic [Width-1:0] gp_raw_i,
    output logic [Width-1:0] gp_o,
    output logic [Width-1:0] gp_rise_o,
    output logic [Width-1:0] gp_fall_o
`ifdef GPI_DEBOUNCE_IRQ_EN
    ,
    input  logic [Width-1:0] change_clr_i,
    output logic [Width-1:0] change_o,
    output logic             irq_o
`endif
);

    localparam int unsigned CntW = $clog2(DebounceCycles + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);
    // Synchroniser reset value chosen so the post-inversion level equals ResetValue.
    localparam logic [Width-1:0] SyncRst = ResetValue ^ InvertMask;

    logic [Width-1:0] sync1_q;
    logic [Width-1:0] sync2_q;
    logic [Width-1:0] sync_c;
    logic [Width-1:0] stable_q;
    logic [Width-1:0] stable_d;
    logic [Width-1:0] rise_q;
    logic [Width-1:0] rise_d;
    logic [Width-1:0] fall_q;
    logic [Width-1:0] fall_d;
    logic [CntW-1:0]  cnt_q [Width];
    logic [CntW-1:0]  cnt_d [Width];

    assign sync_c = sync2_q ^ InvertMask;

    // Two-flop synchroniser.
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            sync1_q <= SyncRst;
            sync2_q <= SyncRst;
        end else begin
            sync1_q <= gp_raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Per-bit debounce: any cycle matching the stable level restarts the count.
    always_comb begin
        stable_d = stable_q;
        rise_d   = '0;
        fall_d   = '0;
        for (int i = 0; i < int'(Width); i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync_c[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntLast) begin
                stable_d[i] = sync_c[i];
                cnt_d[i]    = '0;
                rise_d[i]   = sync_c[i];
                fall_d[i]   = ~sync_c[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CntW'(1);
            end
        end
    end

    // Debounce state and strobe registers.
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            stable_q <= ResetValue;
            rise_q   <= '0;
            fall_q   <= '0;
            for (int i = 0; i < int'(Width); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            for (int i = 0; i < int'(Width); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign gp_o      = stable_q;
    assign gp_rise_o = rise_q;
    assign gp_fall_o = fall_q;

`ifdef GPI_DEBOUNCE_IRQ_EN
    logic [Width-1:0] change_q;
    logic [Width-1:0] change_d;
    logic             irq_q;

    // Sticky change flags; a strobe in the same cycle as a clear keeps the flag set.
    always_comb begin
        change_d = change_q;
        change_d = (change_q & ~change_clr_i) | rise_q | fall_q;
    end

    // irq tracks the next flag value so it moves together with change_o.
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            change_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            change_q <= change_d;
            irq_q    <= |change_d;
        end
    end

    assign change_o = change_q;
    assign irq_o    = irq_q;
`endif

endmodule

// File: tb/tb_gpi_debounce.sv
// Directed self-checking bench for gpi_debounce (Width=13, DebounceCycles=4).
module tb_gpi_debounce;

    localparam int unsigned W = 13;

    logic         clk_sys;
    logic         rst_sys_n;
    logic [W-1:0] gp_raw;
    logic [W-1:0] gp;
    logic [W-1:0] gp_rise;
    logic [W-1:0] gp_fall;
`ifdef GPI_DEBOUNCE_IRQ_EN
    logic [W-1:0] change_clr;
    logic [W-1:0] change;
    logic         irq;
`endif

    int checks = 0;
    int errors = 0;

    gpi_debounce #(
        .Width         (W),
        .DebounceCycles(4),
        .InvertMask    ({W{1'b1}}),
        .ResetValue    ({W{1'b0}})
    ) dut (
        .clk_sys_i   (clk_sys),
        .rst_sys_ni  (rst_sys_n),
        .gp_raw_i    (gp_raw),
        .gp_o        (gp),
        .gp_rise_o   (gp_rise),
        .gp_fall_o   (gp_fall)
`ifdef GPI_DEBOUNCE_IRQ_EN
        ,
        .change_clr_i(change_clr),
        .change_o    (change),
        .irq_o       (irq)
`endif
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // Advance n rising edges, then settle 1 ns past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [W-1:0] e_gp,
                           input logic [W-1:0] e_rise, input logic [W-1:0] e_fall);
        chk({tag, ".gp"},   gp,      e_gp);
        chk({tag, ".rise"}, gp_rise, e_rise);
        chk({tag, ".fall"}, gp_fall, e_fall);
    endtask

    initial begin
        rst_sys_n = 1'b0;
        gp_raw    = {W{1'b1}};
`ifdef GPI_DEBOUNCE_IRQ_EN
        change_clr = '0;
`endif
        #1;
        chk_all("reset", 13'h0000, 13'h0000, 13'h0000);
`ifdef GPI_DEBOUNCE_IRQ_EN
        chk("reset.change", change, 13'h0000);
        chk("reset.irq", W'(irq), 13'h0000);
`endif
        tick(3);
        rst_sys_n = 1'b1;

        // Idle pads (all released) must never move gp.
        for (int c = 0; c < 20; c++) begin
            tick(1);
            chk_all("idle", 13'h0000, 13'h0000, 13'h0000);
        end

        // Clean press on bit 3: accepted on the 6th edge.
        gp_raw[3] = 1'b0;
        tick(5);
        chk_all("press3.early", 13'h0000, 13'h0000, 13'h0000);
        tick(1);
        chk_all("press3.accept", 13'h0008, 13'h0008, 13'h0000);
        tick(1);
        chk_all("press3.after", 13'h0008, 13'h0000, 13'h0000);

        // Clean release on bit 3.
        gp_raw[3] = 1'b1;
        tick(5);
        chk_all("rel3.early", 13'h0008, 13'h0000, 13'h0000);
        tick(1);
        chk_all("rel3.accept", 13'h0000, 13'h0000, 13'h0001 << 3);
        tick(1);
        chk_all("rel3.after", 13'h0000, 13'h0000, 13'h0000);

        // Bounce: low 3, high 1, low held; accept 4 edges after final low reaches sync.
        gp_raw[3] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick(1);
            chk_all("bounce.lo", 13'h0000, 13'h0000, 13'h0000);
        end
        gp_raw[3] = 1'b1;
        tick(1);
        chk_all("bounce.hi", 13'h0000, 13'h0000, 13'h0000);
        gp_raw[3] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick(1);
            chk_all("bounce.hold", 13'h0000, 13'h0000, 13'h0000);
        end
        tick(1);
        chk_all("bounce.accept", 13'h0008, 13'h0008, 13'h0000);
        tick(1);
        chk_all("bounce.after", 13'h0008, 13'h0000, 13'h0000);

        // Simultaneous press on bits 0 and 12.
        gp_raw[0]  = 1'b0;
        gp_raw[12] = 1'b0;
        tick(5);
        chk_all("dual.early", 13'h0008, 13'h0000, 13'h0000);
        tick(1);
        chk_all("dual.accept", 13'h1009, 13'h1001, 13'h0000);
        tick(1);
        chk_all("dual.after", 13'h1009, 13'h0000, 13'h0000);

        // Reset at cnt=2 during a press on bit 5.
        gp_raw[5] = 1'b0;
        tick(4);
        chk_all("midrst.count", 13'h1009, 13'h0000, 13'h0000);
        rst_sys_n = 1'b0;
        #1;
        chk_all("midrst.asserted", 13'h0000, 13'h0000, 13'h0000);
        tick(2);
        chk_all("midrst.held", 13'h0000, 13'h0000, 13'h0000);
        rst_sys_n = 1'b1;
        tick(5);
        chk_all("midrst.early", 13'h0000, 13'h0000, 13'h0000);
        tick(1);
        chk_all("midrst.accept", 13'h1029, 13'h1029, 13'h0000);
        tick(1);
        chk_all("midrst.after", 13'h1029, 13'h0000, 13'h0000);

`ifdef GPI_DEBOUNCE_IRQ_EN
        chk("irq.set_after_rst", change, 13'h1029);
        chk("irq.irq_after_rst", W'(irq), 13'h0001);
        change_clr = {W{1'b1}};
        tick(1);
        change_clr = '0;
        chk("irq.cleared", change, 13'h0000);
        chk("irq.irq_cleared", W'(irq), 13'h0000);

        // Accepted fall on bit 5 sets the sticky flag one cycle after the strobe.
        gp_raw[5] = 1'b1;
        tick(6);
        chk_all("irq.fall5", 13'h1009, 13'h0000, 13'h0020);
        chk("irq.pre_change", change, 13'h0000);
        tick(1);
        chk("irq.change5", change, 13'h0020);
        chk("irq.irq5", W'(irq), 13'h0001);
        change_clr[5] = 1'b1;
        tick(1);
        change_clr[5] = 1'b0;
        chk("irq.clr5", change, 13'h0000);
        chk("irq.irq_clr5", W'(irq), 13'h0000);

        // Clear coincident with a new strobe: set wins.
        gp_raw[5] = 1'b0;
        tick(6);
        chk_all("irq.rise5", 13'h1029, 13'h0020, 13'h0000);
        tick(1);
        chk("irq.change_rise5", change, 13'h0020);
        gp_raw[5] = 1'b1;
        tick(6);
        chk_all("irq.fall5b", 13'h1009, 13'h0000, 13'h0020);
        change_clr[5] = 1'b1;
        tick(1);
        change_clr[5] = 1'b0;
        chk("irq.set_wins", change, 13'h0020);
        chk("irq.irq_set_wins", W'(irq), 13'h0001);
        tick(1);
        chk("irq.sticky", change, 13'h0020);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
